// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: byte-serial wide add/subtract sequencer around one shared 8-bit full adder
module fulladder_8bits (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Suma,
  output logic       Cout
);
  assign {Cout, Suma} = {1'b0, A} + {1'b0, B} + {8'd0, Cin};
endmodule

module adder_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  output logic                  ready,
  output logic                  done,
  output logic [8*NBYTES-1:0]   Result,
  output logic                  Cout,
  output logic                  Ovf
);
  localparam int IW = $clog2(NBYTES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [NBYTES-1:0][7:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] sum;
  logic co, last;
  fulladder_8bits u_fa (
    .A(opa_q[idx_q]),
    .B(opb_q[idx_q]),
    .Cin(carry_q),
    .Suma(sum),
    .Cout(co)
  );
  assign last = idx_q == IW'(NBYTES - 1);
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (start) begin
        opa_d   = A;
        opb_d   = op_sub ? ~B : B;
        carry_d = op_sub;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d[idx_q] = sum;
        carry_d      = co;
        idx_d        = last ? '0 : idx_q + IW'(1);
        if (last) begin
          cout_d  = co;
          ovf_d   = (opa_q[NBYTES-1][7] == opb_q[NBYTES-1][7]) && (sum[7] != opa_q[NBYTES-1][7]);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
    end
  end
  assign ready  = state_q == IDLE;
  assign done   = done_q;
  assign Result = res_q;
  assign Cout   = cout_q;
  assign Ovf    = ovf_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: randomized and directed checks of adder_seq_ctrl against an arithmetic model
module tb_adder_seq_ctrl;
  localparam int NB = 4;
  localparam int W = 8 * NB;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_sub = 1'b0;
  logic [W-1:0] A = '0, B = '0, Result;
  logic ready, done, Cout, Ovf;
  int n_tests = 0, n_fail = 0;

  adder_seq_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .A(A), .B(B),
    .ready(ready), .done(done), .Result(Result), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference from plain integer arithmetic on the operands as numbers.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] res, output logic c, output logic v);
    longint ua = longint'(a), ub = longint'(b);
    longint sa = longint'($signed(a)), sb = longint'($signed(b));
    longint su = sub ? ua - ub : ua + ub;
    longint ss = sub ? sa - sb : sa + sb;
    res = W'(su);
    c   = sub ? (ua >= ub) : (su >= (longint'(1) << W));
    v   = (ss > (longint'(1) << (W - 1)) - 1) || (ss < -(longint'(1) << (W - 1)));
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] er;
    logic ec, ev;
    model(a, b, sub, er, ec, ev);
    check({tag, "_res"}, 64'(Result), 64'(er));
    check({tag, "_cout"}, 64'(Cout), 64'(ec));
    check({tag, "_ovf"}, 64'(Ovf), 64'(ev));
  endtask

  // Called at #1 after a posedge with ready high.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int lat = 0, low = 1;
    start = 1'b1; A = a; B = b; op_sub = sub;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; op_sub = 1'($urandom);
    check({tag, "_ready_low"}, 64'(ready), 64'd0);
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!ready) low++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(NB));
    check_out(tag, a, b, sub);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_ready_back"}, 64'(ready), 64'd1);
    check({tag, "_ready_low_cycles"}, 64'(low), 64'(NB + 1));
  endtask

  initial begin
    logic [W-1:0] qa[$], qb[$];
    logic qs[$];
    int last_acc, seen, guard;
    #2;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(Result), 64'd0);
    check("rst_cout", 64'(Cout), 64'd0);
    check("rst_ovf", 64'(Ovf), 64'd0);
    #15 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_carry", 32'h000000FF, 32'h00000001, 1'b0);
    run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_op("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0);
    run_op("ovf_neg", 32'h80000000, 32'h80000000, 1'b0);
    run_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b1);
    run_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b1);
    run_op("sub_equal", 32'h12345678, 32'h12345678, 1'b1);
    run_op("sub_zero", 32'h00000000, 32'h00000000, 1'b1);
    for (int i = 0; i < 20; i++) run_op("rand", $urandom, $urandom, 1'($urandom));

    // Continuous start with operands changing every cycle.
    last_acc = -1;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      A = $urandom; B = $urandom; op_sub = 1'($urandom);
      if (ready) begin
        qa.push_back(A); qb.push_back(B); qs.push_back(op_sub);
        if (last_acc >= 0) check("accept_spacing", 64'(c - last_acc), 64'(NB + 2));
        last_acc = c;
      end
      @(posedge clk); #1;
      if (done) begin
        if (qa.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else check_out("stream", qa.pop_front(), qb.pop_front(), qs.pop_front());
      end
    end
    start = 1'b0;
    guard = 0;
    while (qa.size() > 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
      if (done) check_out("stream", qa.pop_front(), qb.pop_front(), qs.pop_front());
    end
    check("stream_drain", 64'(qa.size()), 64'd0);
    guard = 0;
    while (!ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("stream_idle", 64'(ready), 64'd1);

    // Asynchronous reset during the second RUN cycle.
    run_op("pre_rst", 32'hFFFFFFFF, 32'h80000000, 1'b0);
    start = 1'b1; A = 32'hDEADBEEF; B = 32'h11111111; op_sub = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_result", 64'(Result), 64'd0);
    check("mid_rst_cout", 64'(Cout), 64'd0);
    check("mid_rst_ovf", 64'(Ovf), 64'd0);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no_done_after_rst", 64'(seen), 64'd0);
    run_op("post_rst", 32'h00010000, 32'h0000FFFF, 1'b0);
    check("post_rst_literal", 64'(Result), 64'h0001FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Multi-cycle controller that computes wide add/subtract operations (8*NBYTES bits) using one shared fulladder_8bits instance.
- Processes one byte slice per clock, LSB first, and chains the carry through a register between slices.
- Sits between the ALU operation decoder and the 8-bit adder datapath.
- Uses a start/ready/done handshake.

Parameters:
- NBYTES, 4, number of byte slices per operation (min 2); operand width W = 8*NBYTES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- op_sub  input  1  0 = A+B, 1 = A-B; sampled with start
- A  input  W  operand A; sampled with start
- B  input  W  operand B; sampled with start
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse; Result, Cout and Ovf are valid this cycle
- Result  output  W  sum/difference; held until the next accepted start
- Cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- Ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, done=0, Result=0, Cout=0, Ovf=0.
  - Internal operand registers, carry register and byte index are cleared to 0.
  - Reset takes effect immediately, including mid-operation; the in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On a clk edge with start=1, the block latches:
    - opA = A
    - opB = op_sub ? ~B : B
    - carry = op_sub
    - idx = 0
    - a copy of op_sub
  - Then goes to RUN. start=0 keeps the block in IDLE.
- RUN:
  - ready=0.
  - Adder inputs, combinational: A=opA[8*idx+:8], B=opB[8*idx+:8], Cin=carry.
  - Each edge:
    - Result[8*idx+:8] <= Suma
    - carry <= adder Cout
    - idx <= idx+1
  - At the edge where idx=NBYTES-1:
    - Cout <= adder Cout
    - Ovf <= (opA[W-1]==opB[W-1]) && (Suma[7]!=opA[W-1]), using the post-inversion opB
    - done <= 1
    - state -> DONE
- DONE:
  - done=1 for exactly this cycle, ready=0.
  - Next edge: done <= 0, state -> IDLE.
  - start is ignored in DONE.
- Latency:
  - Start accepted at edge E0; byte k is written at edge E(k+1).
  - done is high in the cycle after edge E(NBYTES), i.e. NBYTES cycles after acceptance.
  - ready returns at E(NBYTES+1).
  - Minimum start-to-start spacing is NBYTES+2 cycles.
- start while RUN/DONE: ignored, with no effect on operands or state. A, B and op_sub may change freely after acceptance.
- Result bytes update progressively during RUN. Consumers must sample only on done.
- Result, Cout and Ovf hold their values from done until the next accepted start's first RUN edge.
- Cout and Ovf are not cleared by start; they update only at the final-byte edge.
- idx width is clog2(NBYTES). No out-of-range slice access is permitted.
- Arithmetic is modulo 2^W:
  - Subtraction is A + ~B + 1 via Cin = 1 on byte 0.
  - Cout for add = unsigned carry; for sub = NOT borrow.

Test Plan:
- Add carry across bytes: A=0x000000FF, B=0x00000001, add -> Result=0x00000100, Cout=0, Ovf=0. done exactly 4 cycles after the accepting edge, single-cycle pulse. ready low for 5 cycles.
- Full ripple wrap: A=0xFFFFFFFF, B=0x00000001, add -> Result=0x00000000, Cout=1, Ovf=0.
- Signed overflow:
  - A=0x7FFFFFFF + B=0x00000001 -> 0x80000000, Cout=0, Ovf=1.
  - A=0x80000000 + B=0x80000000 -> 0x00000000, Cout=1, Ovf=1.
- Subtract:
  - 0x00000005 - 0x00000007 -> 0xFFFFFFFE, Cout=0, Ovf=0.
  - 0x80000000 - 0x00000001 -> 0x7FFFFFFF, Cout=1, Ovf=1.
  - 0x12345678 - 0x12345678 -> 0x00000000, Cout=1, Ovf=0.
- Handshake:
  - Hold start=1 continuously with operands changing every cycle. Each operation uses only the operands present on its accepting edge.
  - Accepts occur exactly every 6 cycles.
  - start pulses during RUN/DONE are ignored.
- Reset mid-op: assert rst_n=0 asynchronously (between edges) during the 2nd RUN cycle.
  - Immediately: ready=1, done=0, Result=0, Cout=0, Ovf=0.
  - No done pulse follows.
  - After release, a fresh add 0x00010000 + 0x0000FFFF -> 0x0001FFFF, Cout=0.
